// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Sequential instruction prefetcher in front of a single-port,
//                combinational-read 32-bit memory. Execute-stage load/store
//                requests take the port first. Taken branches flush the
//                prefetch FIFO and redirect fetch. Out-of-range fetch
//                addresses raise a sticky fault that only a branch or reset
//                clears.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MEM_BYTES  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        dreq_valid,
    input  logic        dreq_write,
    input  logic [31:0] dreq_addr,
    input  logic [31:0] dreq_wdata,
    output logic        dreq_ready,
    output logic        dreq_rvalid,
    output logic [31:0] dreq_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    // Highest legal word start is MEM_BYTES-4, so anything >= MEM_BYTES-3 faults.
    localparam logic [31:0]        c_PC_LIMIT = 32'(MEM_BYTES - 3);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]          fifo_data_q [FIFO_DEPTH];
    logic [31:0]          fifo_pc_q   [FIFO_DEPTH];
    logic                 instr_valid_q, instr_valid_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          instr_pc_q, instr_pc_d;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;

    logic                 w_pop;
    logic                 w_room;
    logic                 w_fetch_try;
    logic                 w_in_range;
    logic                 w_push;
    logic                 w_fault;
    logic                 w_load;
    logic                 w_head_is_new;
    logic                 w_unused_bits;

    // Only word-aligned branch targets are used; the low bits are dropped.
    assign w_unused_bits = &{1'b0, branch_target[1:0]};

    // ------------------------------------------------------------------
    // Handshake and fetch decision
    // ------------------------------------------------------------------
    // A branch discards the FIFO, so a same-cycle pop must not be counted.
    assign w_pop       = instr_valid_q & instr_ready & ~branch_taken;
    assign w_room      = (count_q < c_DEPTH) | (instr_valid_q & instr_ready);
    assign w_fetch_try = (state_q == ST_RUN) & ~dreq_valid & ~branch_taken & w_room;
    assign w_in_range  = (fetch_pc_q < c_PC_LIMIT);
    assign w_push      = w_fetch_try & w_in_range;
    assign w_fault     = w_fetch_try & ~w_in_range;
    assign w_load      = dreq_valid & ~dreq_write;

    // The new head is the word being fetched now when nothing older remains.
    assign w_head_is_new = (count_q == '0) | (w_pop & (count_q == c_CNT_W'(1)));

    // Memory port mux: data requests win; everything is quiet while in reset.
    always_comb begin
        mem_address    = fetch_pc_q;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        dreq_ready     = 1'b0;
        if (reset_n && dreq_valid) begin
            mem_address    = dreq_addr;
            mem_write_en   = dreq_write;
            mem_write_data = dreq_wdata;
            dreq_ready     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch state machine
    // ------------------------------------------------------------------
    // Next state: a branch always returns to RUN, an out-of-range fetch parks in FAULT.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = ST_RUN;
        end else if (w_fault) begin
            state_d = ST_FAULT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    // Next fetch PC, occupancy and pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (branch_taken) begin
            fetch_pc_d = {branch_target[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (w_push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - c_CNT_W'(1);
            end
        end
    end

    // Registered head view: either the word just fetched or the next stored entry.
    always_comb begin
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        if (!branch_taken && (count_d != '0)) begin
            instr_valid_d = 1'b1;
            if (w_head_is_new) begin
                instr_d    = mem_read_data;
                instr_pc_d = fetch_pc_q;
            end else begin
                instr_d    = fifo_data_q[rd_ptr_d];
                instr_pc_d = fifo_pc_q[rd_ptr_d];
            end
        end
    end

    // Control registers for fetch PC, FIFO pointers and head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // FIFO storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= mem_read_data;
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Load return path
    // ------------------------------------------------------------------
    // Capture load data at the end of the accepted cycle; rvalid is a single pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= w_load;
            if (w_load) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign dreq_rvalid = rvalid_q;
    assign dreq_rdata  = rdata_q;
    // The fault flag is exactly the FAULT state, which is itself a register.
    assign fetch_fault = (state_q == ST_FAULT);

endmodule
`default_nettype wire
